// File: rtl/uart_cmd_frame_rx.sv
`timescale 1ns/1ps
// UART command receiver: synchronised byte receiver feeding a sync/cmd/payload/checksum frame decoder.
// state | meaning: HUNT | wait for sync byte; CMD | expect command byte; PAY | collect payload; CHK | verify checksum, publish
module uart_cmd_frame_rx #(
    parameter int         CLK_FREQ      = 50_000_000,
    parameter int         UART_BPS      = 9600,
    parameter int         DATA_BITS     = 8,
    parameter int         PARITY        = 0,
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter int         NUM_CH        = 4,
    parameter int         PAYLOAD_BYTES = 2,
    parameter int         TIMEOUT_BITS  = 20
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         uart_rx,
    output logic [3:0]                   cmd_ch,
    output logic [8*PAYLOAD_BYTES-1:0]   cmd_data,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    output logic                         err_parity,
    output logic                         err_frame,
    output logic                         err_chk,
    output logic                         err_cmd,
    output logic                         err_timeout,
    output logic                         err_ovf
);

    localparam int                BAUD_CNT_MAX  = CLK_FREQ / UART_BPS;
    localparam int                BAUD_W        = $clog2(BAUD_CNT_MAX);
    localparam logic [BAUD_W-1:0] BAUD_LAST     = BAUD_W'(BAUD_CNT_MAX - 1);
    localparam logic [BAUD_W-1:0] SAMPLE_AT     = BAUD_W'(BAUD_CNT_MAX / 2 - 1);
    localparam logic [3:0]        LAST_DATA_IDX = 4'(DATA_BITS);
    localparam logic [3:0]        PAR_IDX       = 4'(DATA_BITS + 1);
    localparam bit                PAR_EN        = (PARITY != 0);
    localparam logic              PAR_ODD       = (PARITY == 1);
    localparam int                TO_MAX        = TIMEOUT_BITS * BAUD_CNT_MAX;
    localparam int                TO_W          = $clog2(TO_MAX + 1);
    localparam logic [TO_W-1:0]   TO_LIMIT      = TO_W'(TO_MAX);
    localparam int                IDX_W         = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX      = IDX_W'(PAYLOAD_BYTES - 1);
    localparam logic [4:0]        NUM_CH_C      = 5'(NUM_CH);

    typedef enum logic [1:0] {HUNT, CMD, PAY, CHK} state_t;

    logic [2:0]              r_sync;
    logic                    r_busy;
    logic [BAUD_W-1:0]       r_baud_cnt;
    logic [3:0]              r_bit_idx;
    logic [7:0]              r_shift;
    logic                    r_perr;
    logic                    r_byte_stb;
    logic [7:0]              r_byte;
    logic                    r_byte_perr;
    logic                    r_byte_ferr;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [7:0]              r_cmd;
    logic [8*PAYLOAD_BYTES-1:0] r_pay;
    logic [IDX_W-1:0]        r_idx;
    logic [TO_W-1:0]         r_idle_cnt;

    logic w_rx, w_start, w_sample, w_par_err;
    logic w_byte_err, w_timeout, w_accept, w_load, w_ovf;
    logic w_ld_cmd, w_ld_pay, w_idx_clr, w_frame_done, w_e_cmd, w_e_chk, w_e_to;
    logic [7:0] w_chk_calc;

    // Stage 2 is the sampled line; a stage-3 high / stage-2 low pair is a falling edge.
    assign w_rx      = r_sync[1];
    assign w_start   = ~r_busy & r_sync[2] & ~r_sync[1];
    assign w_sample  = r_busy & (r_baud_cnt == SAMPLE_AT);
    assign w_par_err = (^r_shift) ^ w_rx ^ PAR_ODD;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_sync <= 3'b111;
        end else begin
            r_sync <= {r_sync[1:0], uart_rx};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_busy      <= 1'b0;
            r_baud_cnt  <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_perr      <= 1'b0;
            r_byte_stb  <= 1'b0;
            r_byte      <= '0;
            r_byte_perr <= 1'b0;
            r_byte_ferr <= 1'b0;
        end else begin
            r_byte_stb <= 1'b0;
            if (!r_busy) begin
                if (w_start) begin
                    r_busy     <= 1'b1;
                    r_baud_cnt <= '0;
                    r_bit_idx  <= '0;
                    r_shift    <= '0;
                    r_perr     <= 1'b0;
                end
            end else begin
                r_baud_cnt <= (r_baud_cnt == BAUD_LAST) ? '0 : r_baud_cnt + 1'b1;
                if (w_sample) begin
                    r_bit_idx <= r_bit_idx + 1'b1;
                    if (r_bit_idx == 4'd0) begin
                        if (w_rx) r_busy <= 1'b0;
                    end else if (r_bit_idx <= LAST_DATA_IDX) begin
                        r_shift <= {w_rx, r_shift[7:1]};
                    end else if (PAR_EN && (r_bit_idx == PAR_IDX)) begin
                        r_perr <= w_par_err;
                    end else begin
                        // Short characters land in the top bits; shift down to zero-extend.
                        r_busy      <= 1'b0;
                        r_byte_stb  <= 1'b1;
                        r_byte      <= r_shift >> (8 - DATA_BITS);
                        r_byte_perr <= r_perr;
                        r_byte_ferr <= ~w_rx;
                    end
                end
            end
        end
    end

    always_comb begin
        w_chk_calc = r_cmd;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            w_chk_calc = w_chk_calc ^ r_pay[8*i +: 8];
        end
    end

    assign w_byte_err = r_byte_perr | r_byte_ferr;
    assign w_timeout  = (r_state != HUNT) && (r_idle_cnt == TO_LIMIT);
    assign w_accept   = cmd_valid & cmd_ready;
    assign w_load     = w_frame_done & (~cmd_valid | w_accept);
    assign w_ovf      = w_frame_done & cmd_valid & ~w_accept;

    always_comb begin
        w_state_nxt  = r_state;
        w_ld_cmd     = 1'b0;
        w_ld_pay     = 1'b0;
        w_idx_clr    = 1'b0;
        w_frame_done = 1'b0;
        w_e_cmd      = 1'b0;
        w_e_chk      = 1'b0;
        w_e_to       = 1'b0;
        if (r_byte_stb) begin
            if (w_byte_err) begin
                w_state_nxt = HUNT;
            end else begin
                case (r_state)
                    HUNT: if (r_byte == SYNC_BYTE) w_state_nxt = CMD;
                    CMD: begin
                        w_ld_cmd = 1'b1;
                        if ({1'b0, r_byte[7:4]} >= NUM_CH_C) begin
                            w_e_cmd     = 1'b1;
                            w_state_nxt = HUNT;
                        end else begin
                            w_idx_clr   = 1'b1;
                            w_state_nxt = PAY;
                        end
                    end
                    PAY: begin
                        w_ld_pay = 1'b1;
                        if (r_idx == LAST_IDX) w_state_nxt = CHK;
                    end
                    CHK: begin
                        w_state_nxt = HUNT;
                        if (r_byte == w_chk_calc) w_frame_done = 1'b1;
                        else                      w_e_chk      = 1'b1;
                    end
                    default: w_state_nxt = HUNT;
                endcase
            end
        end else if (w_timeout) begin
            w_e_to      = 1'b1;
            w_state_nxt = HUNT;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= HUNT;
            r_cmd       <= '0;
            r_pay       <= '0;
            r_idx       <= '0;
            r_idle_cnt  <= '0;
            cmd_valid   <= 1'b0;
            cmd_ch      <= '0;
            cmd_data    <= '0;
            err_parity  <= 1'b0;
            err_frame   <= 1'b0;
            err_chk     <= 1'b0;
            err_cmd     <= 1'b0;
            err_timeout <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ld_cmd) r_cmd <= r_byte;
            if (w_idx_clr)     r_idx <= '0;
            else if (w_ld_pay) r_idx <= r_idx + 1'b1;
            for (int i = 0; i < PAYLOAD_BYTES; i++) begin
                if (w_ld_pay && (r_idx == IDX_W'(i))) r_pay[8*i +: 8] <= r_byte;
            end
            // Idle counter holds the number of cycles since the last byte strobe, saturating.
            if (r_byte_stb)                  r_idle_cnt <= TO_W'(1);
            else if (r_idle_cnt != TO_LIMIT) r_idle_cnt <= r_idle_cnt + 1'b1;

            err_parity  <= r_byte_stb & r_byte_perr;
            err_frame   <= r_byte_stb & r_byte_ferr;
            err_chk     <= w_e_chk;
            err_cmd     <= w_e_cmd;
            err_timeout <= w_e_to;
            err_ovf     <= w_ovf;

            if (w_load) begin
                cmd_valid <= 1'b1;
                cmd_ch    <= r_cmd[7:4];
                cmd_data  <= r_pay;
            end else if (w_accept) begin
                cmd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_frame_rx.sv
`timescale 1ns/1ps
// Scoreboard bench: a no-parity instance for framing/handshake/timeout and an even-parity instance.
module tb_uart_cmd_frame_rx;

    localparam int BIT_CLK = 10;
    // Start bit driven just after posedge P0 -> byte strobe after posedge P0+98
    // (2 sync flops + edge detect, 5 counts to mid start bit, 9 more bit periods).
    localparam int STB_LAT = 98;
    localparam int TO_CYC  = 200;

    typedef struct {
        logic [3:0]  ch;
        logic [15:0] data;
    } cmd_t;

    logic clk = 1'b0, rst = 1'b1;
    logic rx0 = 1'b1, rx1 = 1'b1, ready0 = 1'b1, ready1 = 1'b1;
    logic [3:0]  cmd_ch, p_ch;
    logic [15:0] cmd_data, p_data;
    logic cmd_valid, err_parity, err_frame, err_chk, err_cmd, err_timeout, err_ovf;
    logic p_valid, p_err_par, p_err_frm, p_err_chk, p_err_cmd, p_err_to, p_err_ovf;

    int cyc = 0, t_start = 0, n_chk = 0, n_fail = 0;
    int e_par = 0, e_frm = 0, e_chk = 0, e_cmd = 0, e_to = 0, e_ovf = 0;
    int pe_par = 0, pe_other = 0, p_cmd_cnt = 0;
    int rise_cyc = -1, fall_cyc = -1, to_cyc = -1;
    cmd_t sb[$];
    cmd_t sbp[$];

    uart_cmd_frame_rx #(.CLK_FREQ(1_000_000), .UART_BPS(100_000)) dut (
        .sys_clk(clk), .sys_rst(rst), .uart_rx(rx0),
        .cmd_ch(cmd_ch), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(ready0),
        .err_parity(err_parity), .err_frame(err_frame), .err_chk(err_chk),
        .err_cmd(err_cmd), .err_timeout(err_timeout), .err_ovf(err_ovf)
    );

    uart_cmd_frame_rx #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .PARITY(2)) dut_p (
        .sys_clk(clk), .sys_rst(rst), .uart_rx(rx1),
        .cmd_ch(p_ch), .cmd_data(p_data), .cmd_valid(p_valid), .cmd_ready(ready1),
        .err_parity(p_err_par), .err_frame(p_err_frm), .err_chk(p_err_chk),
        .err_cmd(p_err_cmd), .err_timeout(p_err_to), .err_ovf(p_err_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a posedge; returns just after a posedge with the line at its stop level.
    task automatic send_byte(input logic [7:0] b, input bit sel, input bit bad_par, input bit bad_stop);
        logic [10:0] bits;
        int n;
        bits    = 11'h7FF;
        bits[0] = 1'b0;
        bits[8:1] = b;
        if (sel) begin
            bits[9]  = (^b) ^ bad_par;
            bits[10] = ~bad_stop;
            n = 11;
        end else begin
            bits[9] = ~bad_stop;
            n = 10;
        end
        t_start = cyc;
        for (int i = 0; i < n; i++) begin
            if (sel) rx1 = bits[i]; else rx0 = bits[i];
            idle(BIT_CLK);
        end
        if (bad_stop) begin
            if (sel) rx1 = 1'b1; else rx0 = 1'b1;
            idle(2 * BIT_CLK);
        end
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] k, input bit sel);
        send_byte(8'hA5, sel, 1'b0, 1'b0);
        send_byte(c,  sel, 1'b0, 1'b0);
        send_byte(d0, sel, 1'b0, 1'b0);
        send_byte(d1, sel, 1'b0, 1'b0);
        send_byte(k,  sel, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        cmd_t e;
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (err_parity) e_par++;
                if (err_frame)  e_frm++;
                if (err_chk)    e_chk++;
                if (err_cmd)    e_cmd++;
                if (err_ovf)    e_ovf++;
                if (err_timeout) begin
                    e_to++;
                    to_cyc = cyc;
                end
                if (cmd_valid && !prev_valid) rise_cyc = cyc;
                if (!cmd_valid && prev_valid) fall_cyc = cyc;
                if (cmd_valid && ready0) begin
                    if (sb.size() == 0) begin
                        check_eq("sb_unexpected_cmd", 32'(sb.size()), 32'd1);
                    end else begin
                        e = sb.pop_front();
                        check_eq("cmd_ch", 32'(cmd_ch), 32'(e.ch));
                        check_eq("cmd_data", 32'(cmd_data), 32'(e.data));
                    end
                end
                if (p_err_par) pe_par++;
                if (p_err_frm || p_err_chk || p_err_cmd || p_err_to || p_err_ovf) pe_other++;
                if (p_valid) begin
                    p_cmd_cnt++;
                    if (sbp.size() == 0) begin
                        check_eq("p_sb_unexpected_cmd", 32'(sbp.size()), 32'd1);
                    end else begin
                        e = sbp.pop_front();
                        check_eq("p_cmd_ch", 32'(p_ch), 32'(e.ch));
                        check_eq("p_cmd_data", 32'(p_data), 32'(e.data));
                    end
                end
            end
            prev_valid = cmd_valid;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got cycle %0d, expected completion", cyc);
        $fatal(1);
    end

    initial begin : stim
        int t;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", 32'(cmd_valid), 32'd0);
        check_eq("rst_ch", 32'(cmd_ch), 32'd0);
        check_eq("rst_data", 32'(cmd_data), 32'd0);
        check_eq("rst_err", 32'({err_parity, err_frame, err_chk, err_cmd, err_timeout, err_ovf}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(5);

        // Basic frame, consumer always ready
        sb.push_back('{ch: 4'd1, data: 16'h5634});
        send_frame(8'h12, 8'h34, 8'h56, 8'h70, 1'b0);
        t = t_start;
        idle(3);
        check_eq("t1_valid_rise", 32'(rise_cyc), 32'(t + STB_LAT + 1));
        check_eq("t1_valid_fall", 32'(fall_cyc), 32'(t + STB_LAT + 2));
        check_eq("t1_sb_drained", 32'(sb.size()), 32'd0);

        // Bad checksum, then an immediately following good frame
        rise_cyc = -1;
        send_frame(8'h12, 8'h34, 8'h56, 8'h71, 1'b0);
        idle(2);
        check_eq("t2_no_valid", 32'(rise_cyc), 32'hFFFF_FFFF);
        sb.push_back('{ch: 4'd1, data: 16'h5634});
        send_frame(8'h12, 8'h34, 8'h56, 8'h70, 1'b0);
        idle(3);
        check_eq("t2_err_chk", 32'(e_chk), 32'd1);
        check_eq("t2_sb_drained", 32'(sb.size()), 32'd0);

        // Start-bit glitch between the sync byte and the rest of a frame
        send_byte(8'h00, 1'b0, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0, 1'b0);
        send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
        idle(5);
        rx0 = 1'b0;
        idle(3);
        rx0 = 1'b1;
        idle(15);
        sb.push_back('{ch: 4'd1, data: 16'h5634});
        send_byte(8'h12, 1'b0, 1'b0, 1'b0);
        send_byte(8'h34, 1'b0, 1'b0, 1'b0);
        send_byte(8'h56, 1'b0, 1'b0, 1'b0);
        send_byte(8'h70, 1'b0, 1'b0, 1'b0);
        idle(3);
        check_eq("t3_sb_drained", 32'(sb.size()), 32'd0);
        check_eq("t3_errs", 32'(e_par + e_frm + e_cmd + e_to + e_ovf), 32'd0);

        // Channel out of range
        send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
        send_byte(8'h52, 1'b0, 1'b0, 1'b0);
        idle(3);
        check_eq("t4_err_cmd", 32'(e_cmd), 32'd1);

        // Inter-byte timeout inside a frame
        send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0, 1'b0);
        t = t_start;
        idle(300);
        check_eq("t5_err_timeout_cnt", 32'(e_to), 32'd1);
        check_eq("t5_err_timeout_time", 32'(to_cyc), 32'(t + STB_LAT + 1 + TO_CYC));

        // Stop bit low aborts the frame; the trailing bytes must not complete one
        rise_cyc = -1;
        send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
        send_byte(8'h12, 1'b0, 1'b0, 1'b1);
        send_byte(8'h34, 1'b0, 1'b0, 1'b0);
        send_byte(8'h56, 1'b0, 1'b0, 1'b0);
        send_byte(8'h70, 1'b0, 1'b0, 1'b0);
        idle(3);
        check_eq("t5_err_frame", 32'(e_frm), 32'd1);
        check_eq("t5_abort_no_valid", 32'(rise_cyc), 32'hFFFF_FFFF);

        // Overflow: second frame dropped, first retained
        ready0 = 1'b0;
        sb.push_back('{ch: 4'd1, data: 16'h5634});
        send_frame(8'h12, 8'h34, 8'h56, 8'h70, 1'b0);
        send_frame(8'h23, 8'hAA, 8'hBB, 8'h32, 1'b0);
        idle(3);
        check_eq("t6_err_ovf", 32'(e_ovf), 32'd1);
        check_eq("t6_hold_ch", 32'(cmd_ch), 32'd1);
        check_eq("t6_hold_data", 32'(cmd_data), 32'h5634);
        ready0 = 1'b1;
        idle(3);
        ready0 = 1'b0;
        check_eq("t6_sb_drained", 32'(sb.size()), 32'd0);

        // Accept on the exact cycle a new frame completes
        sb.push_back('{ch: 4'd3, data: 16'h0201});
        send_frame(8'h30, 8'h01, 8'h02, 8'h33, 1'b0);
        sb.push_back('{ch: 4'd0, data: 16'h00FF});
        send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0, 1'b0);
        send_byte(8'hFF, 1'b0, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0, 1'b0);
        fork
            send_byte(8'hFE, 1'b0, 1'b0, 1'b0);
            begin
                idle(STB_LAT);
                ready0 = 1'b1;
                idle(1);
                ready0 = 1'b0;
            end
        join
        idle(3);
        check_eq("t7_no_ovf", 32'(e_ovf), 32'd1);
        check_eq("t7_valid_held", 32'(cmd_valid), 32'd1);
        check_eq("t7_sb_one_left", 32'(sb.size()), 32'd1);
        ready0 = 1'b1;
        idle(3);
        check_eq("t7_sb_drained", 32'(sb.size()), 32'd0);

        // Reset mid-character clears a pending command and the frame state
        ready0 = 1'b0;
        send_frame(8'h12, 8'h34, 8'h56, 8'h70, 1'b0);
        send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
        rx0 = 1'b0;
        idle(25);
        rst = 1'b1;
        idle(3);
        check_eq("t8_rst_valid", 32'(cmd_valid), 32'd0);
        rst = 1'b0;
        rx0 = 1'b1;
        idle(20);
        rise_cyc = -1;
        send_byte(8'h12, 1'b0, 1'b0, 1'b0);
        send_byte(8'h34, 1'b0, 1'b0, 1'b0);
        send_byte(8'h56, 1'b0, 1'b0, 1'b0);
        send_byte(8'h70, 1'b0, 1'b0, 1'b0);
        idle(3);
        check_eq("t8_no_valid", 32'(rise_cyc), 32'hFFFF_FFFF);
        ready0 = 1'b1;

        // Even parity instance: wrong parity bit aborts to HUNT
        send_byte(8'hA5, 1'b1, 1'b0, 1'b0);
        send_byte(8'h12, 1'b1, 1'b1, 1'b0);
        send_byte(8'h34, 1'b1, 1'b0, 1'b0);
        send_byte(8'h56, 1'b1, 1'b0, 1'b0);
        send_byte(8'h70, 1'b1, 1'b0, 1'b0);
        idle(3);
        check_eq("p_err_parity", 32'(pe_par), 32'd1);
        check_eq("p_no_cmd_after_abort", 32'(p_cmd_cnt), 32'd0);
        sbp.push_back('{ch: 4'd1, data: 16'h5634});
        send_frame(8'h12, 8'h34, 8'h56, 8'h70, 1'b1);
        idle(3);
        check_eq("p_cmd_cnt", 32'(p_cmd_cnt), 32'd1);
        check_eq("p_sb_drained", 32'(sbp.size()), 32'd0);
        check_eq("p_other_errs", 32'(pe_other), 32'd0);

        check_eq("final_err_par", 32'(e_par), 32'd0);
        check_eq("final_err_chk", 32'(e_chk), 32'd1);
        check_eq("final_err_cmd", 32'(e_cmd), 32'd1);
        check_eq("final_err_to", 32'(e_to), 32'd1);
        check_eq("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_frame_rx.md
# uart_cmd_frame_rx

Parametrised UART command receiver for the capture system's host control path. Converts a serial command stream into validated, channel-addressed multi-byte commands. Sits between the board UART pin and the camera/ISP parameter registers. Compared with the single-byte nibble decoder, it adds:
- configurable character format (data bits, parity);
- start-bit glitch rejection and stop-bit checking;
- sync-byte framed, checksummed multi-byte commands addressed to one of NUM_CH channels;
- inter-byte timeout;
- a valid/ready output handshake with overflow reporting.

## Interface
- CLK_FREQ, 50_000_000, system clock frequency in Hz
- UART_BPS, 9600, baud rate; BAUD_CNT_MAX = CLK_FREQ/UART_BPS, must be ≥ 8
- DATA_BITS, 8, data bits per character, 5..8
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- SYNC_BYTE, 8'hA5, frame start marker
- NUM_CH, 4, number of addressable channels, 1..16
- PAYLOAD_BYTES, 2, payload bytes per frame, 1..4
- TIMEOUT_BITS, 20, inter-byte timeout in bit periods
- sys_clk  in  1  system clock; all logic on rising edge
- sys_rst  in  1  synchronous, active-high reset
- uart_rx  in  1  asynchronous serial input, idle high
- cmd_ch  out  4  channel index of the accepted command
- cmd_data  out  8*PAYLOAD_BYTES  payload; first received byte in bits [7:0]
- cmd_valid  out  1  command available; held until accepted
- cmd_ready  in  1  consumer accepts when cmd_valid && cmd_ready
- err_parity, err_frame, err_chk, err_cmd, err_timeout, err_ovf  out  1 each  single-cycle error pulses

## Operation
- Input path:
  - uart_rx passes through a 3-flop synchroniser (reset value 1).
  - A start is a 1→0 transition between stages 2 and 3, detected only when the byte receiver is idle.
- Byte receiver:
  - Baud counter runs 0..BAUD_CNT_MAX-1 while busy.
  - The sample strobe fires at count BAUD_CNT_MAX/2-1.
  - Start strobe: if the line is high, the start is a glitch. Return to idle with no error.
  - Data bits are shifted LSB first. Characters with DATA_BITS < 8 are zero-extended to 8 bits.
  - If PARITY ≠ 0, one parity bit follows the data. A mismatch asserts err_parity.
  - Stop bit must read 1, otherwise err_frame.
  - On the stop sample, the receiver returns to idle and issues a one-cycle byte strobe (with error status) on the next cycle. A new start may be detected from the cycle after the stop sample onward.
- Frame FSM states: HUNT, CMD, PAY, CHK.
  - HUNT: an error-free byte equal to SYNC_BYTE → CMD. All other bytes are ignored silently.
  - CMD: store the byte as cmd.
    - cmd[7:4] ≥ NUM_CH → err_cmd, go to HUNT.
    - Otherwise → PAY and clear the payload index.
  - PAY: store the byte at index idx and increment. When idx = PAYLOAD_BYTES-1 → CHK.
  - CHK: compare the byte with the XOR of cmd and all payload bytes.
    - Mismatch → err_chk, go to HUNT.
    - Match: if cmd_valid is already high, pulse err_ovf and drop the frame. Otherwise load cmd_ch = cmd[7:4] and cmd_data, and set cmd_valid. In both cases return to HUNT.
- Byte errors: a parity or frame error in any state other than HUNT aborts to HUNT. The error pulse is still emitted in HUNT.
- Timeout: an idle counter clears on every byte strobe. If it reaches TIMEOUT_BITS*BAUD_CNT_MAX while in CMD, PAY or CHK → err_timeout pulse, go to HUNT.
- Output handshake:
  - cmd_valid clears on the cycle after cmd_valid && cmd_ready.
  - cmd_ch and cmd_data are stable while cmd_valid is high.
- Simultaneous events: if accept and a new frame completion occur in the same cycle, the accept happens first. The new frame is loaded and cmd_valid stays high; no err_ovf.

## Timing
- Reset values:
  - cmd_valid = 0, cmd_ch = 0, cmd_data = 0, all err_* = 0.
  - FSM in HUNT; receiver idle; counters cleared.
- sys_rst mid-character or mid-frame discards everything. A pending cmd_valid is cleared.
- Byte strobe: 1 cycle after the stop-bit sample strobe.
- cmd_valid rises 1 cycle after the CHK byte strobe. Error pulses are registered on the same cycle cmd_valid would rise.
- Frame length: 3 + PAYLOAD_BYTES characters, each 1+DATA_BITS+(PARITY≠0)+1 bits.
- A character arriving back-to-back with no idle bits is received correctly.

## Test plan
All scenarios use CLK_FREQ=1_000_000, UART_BPS=100_000 (10 clk/bit), defaults otherwise.
- A5 12 34 56 (chk = 12^34^56 = 70), 70 → cmd_valid 1 cycle after last byte strobe, cmd_ch=1, cmd_data=16'h5634. With cmd_ready held high → cmd_valid low the next cycle.
- Same frame with chk byte 71 → err_chk one pulse, cmd_valid stays 0. An immediately following valid frame is accepted.
- Bytes 00 33 A5 then a 3-cycle low glitch on uart_rx → no strobes, no errors. A frame sent afterwards is accepted.
- A5 52 … → err_cmd (channel 5 ≥ 4). PARITY=2: byte 12 sent with wrong parity bit → err_parity, FSM to HUNT.
- A5 01 then silence for 200 cycles → err_timeout exactly once at 200 cycles after the byte strobe. A stop bit forced low → err_frame.
- cmd_ready=0, two valid frames back to back → second frame gives err_ovf and first frame data retained. Assert cmd_ready on the exact cycle of the second completion → second frame loaded, no err_ovf.
